// File: rtl/iq_pkg.sv
// Shared types and widths for the issue-queue wakeup/select stage.
package iq_pkg;

  localparam int unsigned TAG_WIDTH     = 6;
  localparam int unsigned PAYLOAD_WIDTH = 32;
  localparam int unsigned N_CDB         = 2;

  function automatic int unsigned entry_width();
    return 2 * TAG_WIDTH + 2 + TAG_WIDTH + PAYLOAD_WIDTH;
  endfunction

  localparam int unsigned ENTRY_WIDTH = entry_width();

  // Queue entry, MSB to LSB
  typedef struct packed {
    logic [TAG_WIDTH-1:0]     src1_tag;
    logic                     src1_rdy;
    logic [TAG_WIDTH-1:0]     src2_tag;
    logic                     src2_rdy;
    logic [TAG_WIDTH-1:0]     dst_tag;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } iq_entry_t;

endpackage

// File: rtl/iq_wakeup_select_if.sv
// Bundle between fifo_ram, the CDB, the execution unit and iq_wakeup_select.
interface iq_wakeup_select_if #(
  parameter int unsigned N_ENTRIES = 8
);
  import iq_pkg::*;

  logic                               flush;
  logic [N_ENTRIES-1:0]               entry_valid;
  logic [N_ENTRIES*ENTRY_WIDTH-1:0]   entry_douts;
  logic                               deq_valid;
  logic [ENTRY_WIDTH-1:0]             deq_data;
  logic                               deq_ready;
  logic [N_ENTRIES-1:0]               deq_sel_onehot;
  logic [N_ENTRIES-1:0]               wr_en;
  logic [N_ENTRIES*ENTRY_WIDTH-1:0]   wr_data;
  logic [N_CDB-1:0]                   cdb_valid;
  logic [N_CDB*TAG_WIDTH-1:0]         cdb_tag;
  logic                               iss_valid;
  logic                               iss_ready;
  logic [ENTRY_WIDTH-1:0]             iss_entry;

  modport master (
    input  flush, entry_valid, entry_douts, deq_valid, deq_data,
           cdb_valid, cdb_tag, iss_ready,
    output deq_ready, deq_sel_onehot, wr_en, wr_data, iss_valid, iss_entry
  );

  modport slave (
    output flush, entry_valid, entry_douts, deq_valid, deq_data,
           cdb_valid, cdb_tag, iss_ready,
    input  deq_ready, deq_sel_onehot, wr_en, wr_data, iss_valid, iss_entry
  );

endinterface

// File: rtl/prio_sel_onehot.sv
// Lowest-index one-hot priority select; all-zero grant when nothing requests.
module prio_sel_onehot #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt_c
);

  // Isolate the lowest set bit
  assign gnt_c = req & (~req + N'(1));

endmodule

// File: rtl/iq_wakeup_select.sv
// CDB wakeup, oldest-ready select and issue register for a fifo_ram issue queue.
// Define IQ_WAKEUP_BYPASS_EN to let an entry woken this cycle be selected this cycle.
module iq_wakeup_select
  import iq_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 8
) (
  input  logic                clk,
  input  logic                rst_aL,
  iq_wakeup_select_if.master  bus
);

  iq_entry_t            woken [N_ENTRIES];
  logic [N_ENTRIES-1:0] hit_any;
  logic [N_ENTRIES-1:0] eligible;
  logic [N_ENTRIES-1:0] sel;
  logic                 load;
  iq_entry_t            load_entry;
  iq_entry_t            iss_q;
  logic                 iss_valid_q;

  function automatic logic cdb_hit(
    input logic [TAG_WIDTH-1:0]       tag,
    input logic [N_CDB-1:0]           vld,
    input logic [N_CDB*TAG_WIDTH-1:0] tags
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < int'(N_CDB); k++) begin
      hit = hit | (vld[k] && (tags[k*TAG_WIDTH +: TAG_WIDTH] == tag));
    end
    return hit;
  endfunction

  // Tag wakeup and eligibility per entry
  always_comb begin
    hit_any  = '0;
    eligible = '0;
    woken    = '{default: '0};
    for (int i = 0; i < int'(N_ENTRIES); i++) begin
      iq_entry_t cur;
      logic      h1;
      logic      h2;
      cur = iq_entry_t'(bus.entry_douts[i*ENTRY_WIDTH +: ENTRY_WIDTH]);
      h1  = !cur.src1_rdy && cdb_hit(cur.src1_tag, bus.cdb_valid, bus.cdb_tag);
      h2  = !cur.src2_rdy && cdb_hit(cur.src2_tag, bus.cdb_valid, bus.cdb_tag);
      woken[i]          = cur;
      woken[i].src1_rdy = cur.src1_rdy | h1;
      woken[i].src2_rdy = cur.src2_rdy | h2;
      hit_any[i]        = h1 | h2;
`ifdef IQ_WAKEUP_BYPASS_EN
      eligible[i] = bus.entry_valid[i] && woken[i].src1_rdy && woken[i].src2_rdy;
`else
      eligible[i] = bus.entry_valid[i] && cur.src1_rdy && cur.src2_rdy;
`endif
    end
  end

  prio_sel_onehot #(.N(N_ENTRIES)) u_sel (
    .req   (eligible),
    .gnt_c (sel)
  );

  assign load = (|eligible) && bus.deq_valid && (!iss_valid_q || bus.iss_ready) && !bus.flush;

  assign bus.deq_ready      = load;
  assign bus.deq_sel_onehot = sel;

  // Write-back in pre-dequeue positions; the departing entry is not written
  always_comb begin
    bus.wr_en   = '0;
    bus.wr_data = '0;
    for (int i = 0; i < int'(N_ENTRIES); i++) begin
      bus.wr_en[i] = bus.entry_valid[i] && hit_any[i] && !(load && sel[i]);
      bus.wr_data[i*ENTRY_WIDTH +: ENTRY_WIDTH] = woken[i];
    end
  end

  always_comb begin
    load_entry          = iq_entry_t'(bus.deq_data);
    load_entry.src1_rdy = 1'b1;
    load_entry.src2_rdy = 1'b1;
  end

  // Issue register; flush drops the held op
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
    end else if (load) begin
      iss_valid_q <= 1'b1;
      iss_q       <= load_entry;
    end else if (bus.iss_ready || bus.flush) begin
      iss_valid_q <= 1'b0;
    end
  end

  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_entry = iss_q;

endmodule

// File: tb/tb_iq_wakeup_select.sv
// Scoreboard bench for iq_wakeup_select with a small fifo_ram stand-in.
module tb_iq_wakeup_select;
  import iq_pkg::*;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst_aL = 1'b0;
  always #5 clk = ~clk;

  iq_wakeup_select_if #(.N_ENTRIES(N)) bus ();

  iq_wakeup_select #(.N_ENTRIES(N)) dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .bus    (bus)
  );

  iq_entry_t ent [N];
  int        cnt;
  iq_entry_t exp_q[$];
  logic      iss_v_m;
  int        n_vec = 0;
  int        n_err = 0;

  // fifo_ram stand-in: thermometer occupancy, oldest at index 0
  always_comb begin
    bus.entry_valid = '0;
    bus.entry_douts = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (i < cnt) begin
        bus.entry_valid[i] = 1'b1;
        bus.entry_douts[i*ENTRY_WIDTH +: ENTRY_WIDTH] = ent[i];
      end
    end
  end

  always_comb begin
    bus.deq_data = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (bus.deq_sel_onehot[i]) bus.deq_data = ent[i];
    end
  end

  assign bus.deq_valid = (cnt != 0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic iq_entry_t mk(input logic [5:0] s1, input logic r1, input logic [5:0] s2,
                                   input logic r2, input logic [5:0] d, input logic [31:0] pl);
    iq_entry_t e;
    e.src1_tag = s1;
    e.src1_rdy = r1;
    e.src2_tag = s2;
    e.src2_rdy = r2;
    e.dst_tag  = d;
    e.payload  = pl;
    return e;
  endfunction

  function automatic logic bcast(input logic [5:0] tag);
    for (int k = 0; k < int'(N_CDB); k++) begin
      if (bus.cdb_valid[k] && bus.cdb_tag[k*TAG_WIDTH +: TAG_WIDTH] == tag) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: predict, compare, push expected issue, then advance the queue model
  task automatic cycle();
    logic [N-1:0] exp_sel;
    logic [N-1:0] exp_wr;
    iq_entry_t    w [N];
    iq_entry_t    iss_e;
    int           seli;
    logic         ld, h1, h2, el, rdy_now, flush_now;
    exp_sel = '0;
    exp_wr  = '0;
    seli    = -1;
    #1;
    for (int i = 0; i < cnt; i++) begin
      w[i] = ent[i];
      h1 = !ent[i].src1_rdy && bcast(ent[i].src1_tag);
      h2 = !ent[i].src2_rdy && bcast(ent[i].src2_tag);
      if (h1) w[i].src1_rdy = 1'b1;
      if (h2) w[i].src2_rdy = 1'b1;
`ifdef IQ_WAKEUP_BYPASS_EN
      el = w[i].src1_rdy && w[i].src2_rdy;
`else
      el = ent[i].src1_rdy && ent[i].src2_rdy;
`endif
      if (el && seli < 0) seli = i;
      exp_wr[i] = h1 || h2;
    end
    if (seli >= 0) exp_sel[seli] = 1'b1;
    rdy_now   = bus.iss_ready;
    flush_now = bus.flush;
    ld = (seli >= 0) && (!iss_v_m || rdy_now) && !flush_now;
    if (ld) exp_wr[seli] = 1'b0;
    check("deq_sel", 64'(bus.deq_sel_onehot), 64'(exp_sel));
    check("deq_ready", 64'(bus.deq_ready), 64'(ld));
    check("wr_en", 64'(bus.wr_en), 64'(exp_wr));
    check("iss_valid", 64'(bus.iss_valid), 64'(iss_v_m));
    for (int i = 0; i < cnt; i++) begin
      if (exp_wr[i]) check("wr_data", 64'(bus.wr_data[i*ENTRY_WIDTH +: ENTRY_WIDTH]), 64'(w[i]));
    end
    if (ld) begin
      iss_e = ent[seli];
      iss_e.src1_rdy = 1'b1;
      iss_e.src2_rdy = 1'b1;
      exp_q.push_back(iss_e);
    end
    @(posedge clk);
    #1;
    iss_v_m = ld ? 1'b1 : ((rdy_now || flush_now) ? 1'b0 : iss_v_m);
    for (int i = 0; i < cnt; i++) begin
      if (exp_wr[i]) ent[i] = w[i];
    end
    if (ld) begin
      for (int j = seli; j < cnt - 1; j++) ent[j] = ent[j+1];
      ent[cnt-1] = '0;
      cnt--;
    end
  endtask

  // Issue-side monitor: the held op must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_aL && bus.iss_valid) begin
      if (exp_q.size() == 0) begin
        check("iss_unexpected", 64'(bus.iss_valid), 64'(0));
      end else begin
        check("iss_entry", 64'(bus.iss_entry), 64'(exp_q[0]));
        if (bus.iss_ready || bus.flush) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < int'(N); i++) ent[i] = '0;
    cnt           = 0;
    iss_v_m       = 1'b0;
    bus.flush     = 1'b0;
    bus.iss_ready = 1'b0;
    bus.cdb_valid = '0;
    bus.cdb_tag   = '0;

    #12;
    check("rst_valid", 64'(bus.iss_valid), 64'(0));
    check("rst_entry", 64'(bus.iss_entry), 64'(0));
    rst_aL = 1'b1;
    @(posedge clk);
    #1;

    // Two ready entries issue back to back
    ent[0] = mk(6'd1, 1'b1, 6'd2, 1'b1, 6'd10, 32'h0000_00A0);
    ent[1] = mk(6'd3, 1'b1, 6'd4, 1'b1, 6'd11, 32'h0000_00A1);
    cnt = 2;
    bus.iss_ready = 1'b1;
    repeat (4) cycle();

    // Wakeup of src1 via CDB 1
    ent[0] = mk(6'd5, 1'b0, 6'd7, 1'b1, 6'd12, 32'h0000_00B0);
    cnt = 1;
    bus.cdb_valid = 2'b10;
    bus.cdb_tag   = {6'd5, 6'd9};
    cycle();
    bus.cdb_valid = 2'b00;
    repeat (3) cycle();

    // Duplicate tags on both buses
    ent[0] = mk(6'd40, 1'b1, 6'd41, 1'b0, 6'd13, 32'h0000_00B1);
    cnt = 1;
    bus.cdb_valid = 2'b11;
    bus.cdb_tag   = {6'd41, 6'd41};
    cycle();
    bus.cdb_valid = 2'b00;
    repeat (2) cycle();

    // Back-pressure: issue register held while entry 2 waits
    ent[0] = mk(6'd8, 1'b1, 6'd9, 1'b1, 6'd14, 32'h0000_00C0);
    cnt = 1;
    bus.iss_ready = 1'b0;
    cycle();
    ent[0] = mk(6'd50, 1'b0, 6'd51, 1'b1, 6'd15, 32'h0000_00C1);
    ent[1] = mk(6'd52, 1'b0, 6'd53, 1'b0, 6'd16, 32'h0000_00C2);
    ent[2] = mk(6'd54, 1'b1, 6'd55, 1'b1, 6'd17, 32'h0000_00C3);
    cnt = 3;
    repeat (3) cycle();
    bus.iss_ready = 1'b1;
    repeat (3) cycle();
    cnt = 0;

    // Flush with a held op and an eligible entry
    ent[0] = mk(6'd60, 1'b1, 6'd61, 1'b1, 6'd18, 32'h0000_00D0);
    cnt = 1;
    bus.iss_ready = 1'b0;
    cycle();
    ent[0] = mk(6'd62, 1'b1, 6'd63, 1'b1, 6'd19, 32'h0000_00D1);
    cnt = 1;
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    bus.iss_ready = 1'b1;
    repeat (3) cycle();

    // Entry 3 selected while a CDB tag matches its second source
    ent[0] = mk(6'd20, 1'b0, 6'd23, 1'b1, 6'd1, 32'h0000_00E0);
    ent[1] = mk(6'd21, 1'b0, 6'd22, 1'b0, 6'd2, 32'h0000_00E1);
    ent[2] = mk(6'd22, 1'b0, 6'd24, 1'b1, 6'd3, 32'h0000_00E2);
`ifdef IQ_WAKEUP_BYPASS_EN
    ent[3] = mk(6'd30, 1'b1, 6'd31, 1'b0, 6'd4, 32'h0000_00E3);
`else
    ent[3] = mk(6'd30, 1'b1, 6'd31, 1'b1, 6'd4, 32'h0000_00E3);
`endif
    cnt = 4;
    bus.cdb_valid = 2'b11;
    bus.cdb_tag   = {6'd31, 6'd21};
    cycle();
    bus.cdb_valid = 2'b00;
    repeat (2) cycle();
    cnt = 0;

    // Asynchronous reset with an op held
    ent[0] = mk(6'd33, 1'b1, 6'd34, 1'b1, 6'd5, 32'h0000_00F0);
    cnt = 1;
    bus.iss_ready = 1'b0;
    cycle();
    check("pre_rst_valid", 64'(bus.iss_valid), 64'(1));
    rst_aL = 1'b0;
    #1;
    check("arst_valid", 64'(bus.iss_valid), 64'(0));
    check("arst_entry", 64'(bus.iss_entry), 64'(0));
    exp_q.delete();
    iss_v_m = 1'b0;
    #2;
    rst_aL = 1'b1;
    @(posedge clk);
    #1;
    ent[0] = mk(6'd35, 1'b1, 6'd36, 1'b1, 6'd6, 32'h0000_00F1);
    cnt = 1;
    bus.iss_ready = 1'b1;
    repeat (3) cycle();

    cnt = 0;
    repeat (2) cycle();
    check("sb_drain", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
